// File: rtl/s_axi_full_mem.sv
// rtl/s_axi_full_mem.sv - AXI4 full slave over a 32-bit word memory; WRAP bursts enabled by S_AXI_FULL_MEM_WRAP_EN
module s_axi_full_mem #(
    parameter int C_ADDR_W    = 12,
    parameter int C_ID_W      = 1,
    parameter int C_MEM_WORDS = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    // write address channel
    input  logic [C_ID_W-1:0]   AWID,
    input  logic [C_ADDR_W-1:0] AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    // write data channel
    input  logic [31:0]         WDATA,
    input  logic [3:0]          WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    // write response channel
    output logic [C_ID_W-1:0]   BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    // read address channel
    input  logic [C_ID_W-1:0]   ARID,
    input  logic [C_ADDR_W-1:0] ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    // read data channel
    output logic [C_ID_W-1:0]   RID,
    output logic [31:0]         RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int MEM_AW = (C_MEM_WORDS > 1) ? $clog2(C_MEM_WORDS) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA}         r_state_t;

    // burst modes held after the address handshake
    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_INCR  = 2'b01;
    localparam logic [1:0] MODE_WRAP  = 2'b10;

    logic [31:0] r_mem [C_MEM_WORDS];

    w_state_t r_wstate, w_wstate_nxt;
    r_state_t r_rstate, w_rstate_nxt;
    logic     r_run;

    logic [C_ID_W-1:0]   r_bid, r_rid;
    logic [C_ADDR_W-1:0] r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt, w_rd_addr;
    logic [7:0]          r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic [1:0]          r_wmode, r_rmode, w_aw_mode, w_ar_mode;
    logic                r_werr, r_rerr, w_aw_err, w_ar_err;
    logic [1:0]          r_bresp, r_rresp;
    logic [31:0]         r_rdata, w_rd_word;
    logic                r_rlast;
    logic                w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                w_w_last, w_w_in, w_w_bad, w_rd_in, w_rd_err;
    logic [MEM_AW-1:0]   w_widx;

    function automatic logic in_range(input logic [C_ADDR_W-1:0] a);
        return 32'(a >> 2) < 32'(C_MEM_WORDS);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [C_ADDR_W-1:0] a);
        return MEM_AW'(a >> 2);
    endfunction

`ifdef S_AXI_FULL_MEM_WRAP_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
`endif

    // classify incoming AW/AR bursts: effective address mode and burst-wide error
    always_comb begin
        w_aw_err  = (AWSIZE != 3'b010) || (AWBURST == 2'b11);
        w_ar_err  = (ARSIZE != 3'b010) || (ARBURST == 2'b11);
        w_aw_mode = (AWBURST == 2'b00) ? MODE_FIXED : MODE_INCR;
        w_ar_mode = (ARBURST == 2'b00) ? MODE_FIXED : MODE_INCR;
`ifdef S_AXI_FULL_MEM_WRAP_EN
        if (AWBURST == 2'b10) begin
            if (wrap_len_ok(AWLEN)) w_aw_mode = MODE_WRAP;
            else                    w_aw_err  = 1'b1;
        end
        if (ARBURST == 2'b10) begin
            if (wrap_len_ok(ARLEN)) w_ar_mode = MODE_WRAP;
            else                    w_ar_err  = 1'b1;
        end
`else
        if (AWBURST == 2'b10) w_aw_err = 1'b1;
        if (ARBURST == 2'b10) w_ar_err = 1'b1;
`endif
    end

    // next beat address for both channels; INCR rolls over naturally at 2^C_ADDR_W
    always_comb begin
        w_waddr_nxt = (r_wmode == MODE_FIXED) ? r_waddr : r_waddr + C_ADDR_W'(4);
        w_raddr_nxt = (r_rmode == MODE_FIXED) ? r_raddr : r_raddr + C_ADDR_W'(4);
`ifdef S_AXI_FULL_MEM_WRAP_EN
        if (r_wmode == MODE_WRAP)
            w_waddr_nxt = (r_waddr & ~C_ADDR_W'({r_wlen, 2'b11}))
                        | ((r_waddr + C_ADDR_W'(4)) & C_ADDR_W'({r_wlen, 2'b11}));
        if (r_rmode == MODE_WRAP)
            w_raddr_nxt = (r_raddr & ~C_ADDR_W'({r_rlen, 2'b11}))
                        | ((r_raddr + C_ADDR_W'(4)) & C_ADDR_W'({r_rlen, 2'b11}));
`endif
    end

    // ready flags stay low until the first clock edge after reset release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    // write and read state registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // write FSM: next state and channel handshake outputs
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = r_run;
                if (AWVALID && r_run) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = 1'b1;
                if (WVALID && w_w_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // read FSM: next state and channel handshake outputs
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = r_run;
                if (ARVALID && r_run) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                w_rvalid = 1'b1;
                if (RREADY && r_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    assign AWREADY = w_awready;
    assign WREADY  = w_wready;
    assign BVALID  = w_bvalid;
    assign ARREADY = w_arready;
    assign RVALID  = w_rvalid;
    assign BID     = r_bid;
    assign BRESP   = r_bresp;
    assign RID     = r_rid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign RLAST   = r_rlast;

    assign w_aw_hs  = AWVALID && w_awready;
    assign w_w_hs   = WVALID && w_wready;
    assign w_b_hs   = BREADY && w_bvalid;
    assign w_ar_hs  = ARVALID && w_arready;
    assign w_r_hs   = RREADY && w_rvalid;
    assign w_w_last = (r_wcnt == r_wlen);
    assign w_w_in   = in_range(r_waddr);
    assign w_w_bad  = !w_w_in || (WLAST != w_w_last);
    assign w_widx   = word_idx(r_waddr);

    // the word presented next: burst start on AR handshake, else the following beat
    assign w_rd_addr = (r_rstate == R_IDLE) ? ARADDR : w_raddr_nxt;
    assign w_rd_in   = in_range(w_rd_addr);
    assign w_rd_word = r_mem[word_idx(w_rd_addr)];
    assign w_rd_err  = ((r_rstate == R_IDLE) ? w_ar_err : r_rerr) || !w_rd_in;

    // write channel bookkeeping: beat count, address step, sticky error, response
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_bid   <= '0;
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_wmode <= MODE_FIXED;
            r_werr  <= 1'b0;
            r_bresp <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_bid   <= AWID;
                r_waddr <= AWADDR;
                r_wlen  <= AWLEN;
                r_wcnt  <= '0;
                r_wmode <= w_aw_mode;
                r_werr  <= w_aw_err;
            end
            if (w_w_hs) begin
                r_waddr <= w_waddr_nxt;
                r_wcnt  <= r_wcnt + 8'd1;
                if (w_w_bad) r_werr <= 1'b1;
                if (w_w_last) r_bresp <= (r_werr || w_w_bad) ? 2'b10 : 2'b00;
            end
            if (w_b_hs) r_bresp <= 2'b00;
        end
    end

    // memory array is never reset; out-of-range beats are simply not written
    always_ff @(posedge ACLK) begin
        if (w_w_hs && w_w_in) begin
            for (int b = 0; b < 4; b++) begin
                if (WSTRB[b]) r_mem[w_widx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // read channel: registered beat loaded on AR handshake and on each non-final R handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rid   <= '0;
            r_raddr <= '0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rmode <= MODE_FIXED;
            r_rerr  <= 1'b0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
            r_rlast <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid   <= ARID;
            r_raddr <= ARADDR;
            r_rlen  <= ARLEN;
            r_rcnt  <= '0;
            r_rmode <= w_ar_mode;
            r_rerr  <= w_ar_err;
            r_rdata <= w_rd_in ? w_rd_word : 32'd0;
            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
            r_rlast <= (ARLEN == 8'd0);
        end else if (w_r_hs) begin
            if (r_rlast) begin
                r_rlast <= 1'b0;
            end else begin
                r_raddr <= w_raddr_nxt;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rdata <= w_rd_in ? w_rd_word : 32'd0;
                r_rresp <= w_rd_err ? 2'b10 : 2'b00;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
        end
    end

endmodule

// File: tb/tb_s_axi_full_mem.sv
// tb/tb_s_axi_full_mem.sv - scoreboard bench for s_axi_full_mem
module tb_s_axi_full_mem;

    localparam int WORDS = 1023;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [0:0]  AWID, ARID, BID, RID;
    logic [11:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mdl [1024];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [3:0]  pat = 4'b1001;

    s_axi_full_mem #(.C_ADDR_W(12), .C_ID_W(1), .C_MEM_WORDS(WORDS)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_berr(input int burst, input int len, input int size);
        if (size != 2 || burst == 3) return 1'b1;
`ifdef S_AXI_FULL_MEM_WRAP_EN
        if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15);
`else
        if (burst == 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int exp_addr(input int start, input int len, input int burst, input int beat);
        int sz, base;
        if (burst == 0) return start;
`ifdef S_AXI_FULL_MEM_WRAP_EN
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            sz   = (len + 1) * 4;
            base = (start / sz) * sz;
            return base + ((start - base) + 4 * beat) % sz;
        end
`endif
        sz = 0;
        base = 0;
        return (start + sz + base + 4 * beat) % 4096;
    endfunction

    task automatic wr_burst(input logic id, input int addr, input int len, input int burst, input int size,
                            input logic [31:0] d0, input logic [3:0] strb, input int wlast_beat);
        int  a, n;
        bit  err;
        logic [31:0] d;
        logic [1:0]  eb;
        err = exp_berr(burst, len, size) || (wlast_beat != len);
        for (int b = 0; b <= len; b++) begin
            a = exp_addr(addr, len, burst, b);
            if (a / 4 >= WORDS) err = 1'b1;
        end
        bq.push_back(err ? 2'b10 : 2'b00);
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWID = id; AWADDR = 12'(addr); AWLEN = 8'(len);
        AWBURST = 2'(burst); AWSIZE = 3'(size);
        n = 0;
        @(negedge ACLK);
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("awready", 32'(AWREADY), 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            d = d0 + 32'(b);
            WVALID = 1'b1; WDATA = d; WSTRB = strb; WLAST = (b == wlast_beat);
            n = 0;
            @(negedge ACLK);
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            chk("wready", 32'(WREADY), 1);
            a = exp_addr(addr, len, burst, b);
            if (a / 4 < WORDS) begin
                for (int l = 0; l < 4; l++)
                    if (strb[l]) mdl[a/4][8*l +: 8] = d[8*l +: 8];
            end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid", 32'(BVALID), 1);
        eb = bq.pop_front();
        chk("bresp", 32'(BRESP), 32'(eb));
        chk("bid", 32'(BID), 32'(id));
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic rd_burst(input logic id, input int addr, input int len, input int burst, input int size,
                            input bit stall);
        rbeat_t e;
        int a, n, cyc;
        bit held;
        logic [31:0] hd;
        logic hl;
        for (int b = 0; b <= len; b++) begin
            a = exp_addr(addr, len, burst, b);
            e.data = (a / 4 < WORDS) ? mdl[a/4] : 32'd0;
            e.resp = (exp_berr(burst, len, size) || a / 4 >= WORDS) ? 2'b10 : 2'b00;
            e.last = (b == len);
            rq.push_back(e);
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARID = id; ARADDR = 12'(addr); ARLEN = 8'(len);
        ARBURST = 2'(burst); ARSIZE = 3'(size);
        n = 0;
        @(negedge ACLK);
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("arready", 32'(ARREADY), 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        cyc = 0;
        held = 1'b0;
        hd = '0;
        hl = 1'b0;
        while (rq.size() > 0 && cyc < 200) begin
            RREADY = stall ? pat[cyc % 4] : 1'b1;
            @(negedge ACLK);
            if (RVALID) begin
                if (held) begin
                    chk("r_hold_data", RDATA, hd);
                    chk("r_hold_last", 32'(RLAST), 32'(hl));
                end
                if (RREADY) begin
                    e = rq.pop_front();
                    chk("rdata", RDATA, e.data);
                    chk("rresp", 32'(RRESP), 32'(e.resp));
                    chk("rlast", 32'(RLAST), 32'(e.last));
                    chk("rid", 32'(RID), 32'(id));
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = RDATA;
                    hl = RLAST;
                end
            end
            @(posedge ACLK); #1;
            cyc++;
        end
        chk("r_beats_left", 32'(rq.size()), 0);
        rq.delete();
        RREADY = 1'b0;
        @(negedge ACLK);
        chk("rvalid_after", 32'(RVALID), 0);
    endtask

    initial begin
        ARESETN = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b0;

        // reset values while ARESETN is held low
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 0);
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_wready", 32'(WREADY), 0);
        chk("rst_bvalid", 32'(BVALID), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_rlast", 32'(RLAST), 0);
        chk("rst_bresp", 32'(BRESP), 0);
        chk("rst_rresp", 32'(RRESP), 0);
        chk("rst_ids", 32'({BID, RID}), 0);
        chk("rst_rdata", RDATA, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        chk("rel_awready_pre", 32'(AWREADY), 0);
        @(posedge ACLK); #1;
        chk("rel_awready", 32'(AWREADY), 1);
        chk("rel_arready", 32'(ARREADY), 1);

        // INCR write/read of four words
        wr_burst(1'b1, 'h010, 3, 1, 2, 32'hA0, 4'hF, 3);
        rd_burst(1'b1, 'h010, 3, 1, 2, 1'b0);

        // byte strobes merge into an existing word
        wr_burst(1'b0, 'h040, 0, 1, 2, 32'h11223344, 4'hF, 0);
        wr_burst(1'b0, 'h040, 0, 1, 2, 32'hFFFFFFFF, 4'h5, 0);
        rd_burst(1'b0, 'h040, 0, 1, 2, 1'b0);

        // eight-beat read with RREADY stalls
        wr_burst(1'b1, 'h010, 7, 1, 2, 32'hB0, 4'hF, 7);
        rd_burst(1'b1, 'h010, 7, 1, 2, 1'b1);

        // top-of-space burst: first beat out of range, second wraps to 0x000
        wr_burst(1'b0, 'hFFC, 1, 1, 2, 32'hC0, 4'hF, 1);
        rd_burst(1'b1, 'hFFC, 1, 1, 2, 1'b0);

        // WRAP read (behaviour depends on build)
        rd_burst(1'b0, 'h018, 3, 2, 2, 1'b0);

        // bad size, reserved burst, FIXED burst, missing WLAST
        rd_burst(1'b1, 'h010, 1, 1, 1, 1'b0);
        wr_burst(1'b1, 'h200, 1, 3, 2, 32'hD0, 4'hF, 1);
        rd_burst(1'b0, 'h200, 1, 1, 2, 1'b0);
        wr_burst(1'b0, 'h080, 2, 0, 2, 32'h70, 4'hF, 2);
        rd_burst(1'b0, 'h080, 2, 0, 2, 1'b0);
        wr_burst(1'b1, 'h0C0, 1, 1, 2, 32'hE0, 4'hF, -1);
        rd_burst(1'b1, 'h0C0, 1, 1, 2, 1'b0);

        // reset in the middle of a four-beat write
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWID = 1'b1; AWADDR = 12'h100; AWLEN = 8'd3; AWBURST = 2'b01; AWSIZE = 3'b010;
        @(negedge ACLK);
        chk("mid_awready", 32'(AWREADY), 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'h55; WSTRB = 4'hF; WLAST = 1'b0;
        @(negedge ACLK);
        chk("mid_wready", 32'(WREADY), 1);
        mdl['h100/4] = 32'h55;
        @(posedge ACLK); #1;
        WDATA = 32'h56;
        #2;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_wready", 32'(WREADY), 0);
        chk("mid_rst_bvalid", 32'(BVALID), 0);
        chk("mid_rst_awready", 32'(AWREADY), 0);
        WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        chk("mid_rel_awready_pre", 32'(AWREADY), 0);
        @(posedge ACLK); #1;
        chk("mid_rel_awready", 32'(AWREADY), 1);
        chk("mid_rel_bvalid", 32'(BVALID), 0);
        rd_burst(1'b0, 'h100, 0, 1, 2, 1'b0);
        rd_burst(1'b1, 'h010, 7, 1, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
